// File: rtl/tlm_sb_pkg.sv
// Shared types for the fabric-side IOSF sideband transmitter.
package tlm_sb_pkg;

  localparam int SB_PAYLOAD_W = 8;

  typedef struct packed {
    logic                    eom;
    logic [SB_PAYLOAD_W-1:0] payload;
  } sb_flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_PC = 2'd1,
    SEND_NP = 2'd2
  } sb_tx_state_e;

endpackage

// File: rtl/tlm_sb_flit_fifo.sv
// Synchronous single-clock FIFO; dout always shows the head entry.
module tlm_sb_flit_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tlm_sb_fabric_tx.sv
// Fabric-side sideband transmitter: per-class message FIFOs serialized onto
// the sb2_tlm put interface under message-credit control, whole messages only.
module tlm_sb_fabric_tx
  import tlm_sb_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int CRD_W      = 4
) (
  input  logic                    tlm_secondary_clock,
  input  logic                    tlm_secondary_reset,
  input  logic                    tx_en,
  input  logic                    pc_push,
  input  logic                    np_push,
  input  logic [SB_PAYLOAD_W-1:0] push_payload,
  input  logic                    push_eom,
  output logic                    pc_full,
  output logic                    np_full,
  input  logic                    tlm_sb2_pccup,
  input  logic                    tlm_sb2_npcup,
  output logic                    sb2_tlm_pcput,
  output logic                    sb2_tlm_npput,
  output logic [SB_PAYLOAD_W-1:0] sb2_tlm_payload,
  output logic                    sb2_tlm_eom,
  output logic                    crd_ovf_err,
  output logic                    push_err
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CRD_W-1:0] CRD_MAX = '1;

  sb_tx_state_e     state, state_nxt;
  sb_flit_t         push_flit, pc_head, np_head;
  logic             pc_empty, np_empty;
  logic             pc_acc, np_acc;
  logic [CNT_W-1:0] pc_msgs, np_msgs;
  logic [CRD_W-1:0] pc_crd, np_crd;
  logic [CRD_W:0]   pc_crd_upd, np_crd_upd;
  logic             first_flit, rr_np;
  logic             pc_start, np_start, pc_eom_tx, np_eom_tx;
  logic             pc_elig, np_elig, decide, grant_pc, grant_np;

  // Saturating credit step; MSB of the result flags an overflowing return.
  function automatic logic [CRD_W:0] crd_update(input logic [CRD_W-1:0] crd,
                                                input logic cup, input logic start);
    logic [CRD_W:0] r;
    case ({cup, start})
      2'b10:   r = (crd == CRD_MAX) ? {1'b1, crd} : {1'b0, crd + 1'b1};
      2'b01:   r = {1'b0, crd - 1'b1};
      default: r = {1'b0, crd};
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] msg_update(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    case ({inc, dec})
      2'b10:   r = cnt + 1'b1;
      2'b01:   r = cnt - 1'b1;
      default: r = cnt;
    endcase
    return r;
  endfunction

  assign push_flit = '{eom: push_eom, payload: push_payload};
  assign pc_acc    = pc_push && !np_push && !pc_full;
  assign np_acc    = np_push && !pc_push && !np_full;

  tlm_sb_flit_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(sb_flit_t))) u_pc_fifo (
    .clk   (tlm_secondary_clock),
    .rst   (tlm_secondary_reset),
    .push  (pc_acc),
    .pop   (sb2_tlm_pcput),
    .din   (push_flit),
    .dout  (pc_head),
    .full  (pc_full),
    .empty (pc_empty)
  );

  tlm_sb_flit_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(sb_flit_t))) u_np_fifo (
    .clk   (tlm_secondary_clock),
    .rst   (tlm_secondary_reset),
    .push  (np_acc),
    .pop   (sb2_tlm_npput),
    .din   (push_flit),
    .dout  (np_head),
    .full  (np_full),
    .empty (np_empty)
  );

  always_comb begin
    sb2_tlm_pcput   = 1'b0;
    sb2_tlm_npput   = 1'b0;
    sb2_tlm_payload = '0;
    sb2_tlm_eom     = 1'b0;
    case (state)
      SEND_PC: begin
        sb2_tlm_pcput   = !pc_empty;
        sb2_tlm_payload = pc_empty ? '0 : pc_head.payload;
        sb2_tlm_eom     = !pc_empty && pc_head.eom;
      end
      SEND_NP: begin
        sb2_tlm_npput   = !np_empty;
        sb2_tlm_payload = np_empty ? '0 : np_head.payload;
        sb2_tlm_eom     = !np_empty && np_head.eom;
      end
      default: ;
    endcase
  end

  assign pc_start  = sb2_tlm_pcput && first_flit;
  assign np_start  = sb2_tlm_npput && first_flit;
  assign pc_eom_tx = sb2_tlm_pcput && pc_head.eom;
  assign np_eom_tx = sb2_tlm_npput && np_head.eom;

  // Eligibility discounts the message/credit being consumed this very cycle
  // so a back-to-back decision on an eom flit sees the post-update view.
  assign pc_elig = tx_en && ((pc_msgs - CNT_W'(pc_eom_tx)) != '0)
                         && ((pc_crd - CRD_W'(pc_start)) != '0);
  assign np_elig = tx_en && ((np_msgs - CNT_W'(np_eom_tx)) != '0)
                         && ((np_crd - CRD_W'(np_start)) != '0);
  assign decide   = (state == IDLE) || pc_eom_tx || np_eom_tx;
  assign grant_pc = decide && pc_elig && (!np_elig || !rr_np);
  assign grant_np = decide && np_elig && (!pc_elig || rr_np);

  always_comb begin
    state_nxt = state;
    if (decide) begin
      if (grant_pc)      state_nxt = SEND_PC;
      else if (grant_np) state_nxt = SEND_NP;
      else               state_nxt = IDLE;
    end
  end

  always_ff @(posedge tlm_secondary_clock) begin
    if (tlm_secondary_reset) state <= IDLE;
    else                     state <= state_nxt;
  end

  assign pc_crd_upd = crd_update(pc_crd, tlm_sb2_pccup, pc_start);
  assign np_crd_upd = crd_update(np_crd, tlm_sb2_npcup, np_start);

  always_ff @(posedge tlm_secondary_clock) begin
    if (tlm_secondary_reset) begin
      first_flit  <= 1'b0;
      rr_np       <= 1'b0;
      pc_crd      <= '0;
      np_crd      <= '0;
      pc_msgs     <= '0;
      np_msgs     <= '0;
      crd_ovf_err <= 1'b0;
      push_err    <= 1'b0;
    end else begin
      if (grant_pc || grant_np)              first_flit <= 1'b1;
      else if (sb2_tlm_pcput || sb2_tlm_npput) first_flit <= 1'b0;
      if (grant_pc)      rr_np <= 1'b1;
      else if (grant_np) rr_np <= 1'b0;
      pc_crd      <= pc_crd_upd[CRD_W-1:0];
      np_crd      <= np_crd_upd[CRD_W-1:0];
      pc_msgs     <= msg_update(pc_msgs, pc_acc && push_eom, pc_eom_tx);
      np_msgs     <= msg_update(np_msgs, np_acc && push_eom, np_eom_tx);
      crd_ovf_err <= crd_ovf_err | pc_crd_upd[CRD_W] | np_crd_upd[CRD_W];
      push_err    <= push_err | (pc_push && np_push) | (pc_push && pc_full)
                              | (np_push && np_full);
    end
  end

endmodule
